// File: rtl/defines.sv
// defines: shared types, opcode constants and register-use record for decode-side logic
package defines;

  typedef logic [31:0] instr_t;
  typedef logic [31:0] data_t;
  typedef logic [4:0]  r_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
  } reg_use_t;

endpackage

// File: rtl/reg_use_decode.sv
// reg_use_decode: opcode to register-operand usage (rs1/rs2 read, rd write)
module reg_use_decode
  import defines::*;
(
  input  instr_t   instr,
  output reg_use_t use_o
);

  logic [6:0] opc;
  logic       unused_bits;

  assign opc         = instr[6:0];
  assign unused_bits = ^instr[31:7];

  // operand classes by opcode; MISC-MEM, SYSTEM and unknown touch no registers
  always_comb begin
    use_o = '0;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL:     use_o = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b1};
      OPC_JALR, OPC_LOAD, OPC_OPIMM:   use_o = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1};
      OPC_OP:                          use_o = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b1};
      OPC_BRANCH, OPC_STORE:           use_o = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0};
      default:                         use_o = '0;
    endcase
  end

endmodule

// File: rtl/regfile_scheduler.sv
// regfile_scheduler: long-op scoreboard, decode stall and fast/slow writeback port arbiter
module regfile_scheduler
  import defines::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  input  instr_t instr,
  input  logic   dec_valid,
  input  logic   dec_long,
  output logic   dec_stall,
  input  logic   fast_valid,
  input  r_t     fast_addr,
  input  data_t  fast_data,
  input  logic   slow_valid,
  input  r_t     slow_addr,
  input  data_t  slow_data,
  output logic   slow_ready,
  output logic   wren,
  output r_t     waddr,
  output data_t  wd
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                starve_q, starve_d;
  reg_use_t            ru;
  r_t                  rs1, rs2, rd;
  logic                fast_win, hazard, issue;

  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign rd  = instr[11:7];

  reg_use_decode u_dec (.instr(instr), .use_o(ru));

  // write port mux: a real fast write always wins; fast to x0 frees the port for slow
  always_comb begin
    fast_win   = fast_valid && fast_addr != '0;
    slow_ready = !fast_win && slow_valid;
    wren       = fast_win || (slow_ready && slow_addr != '0);
    waddr      = fast_win ? fast_addr : slow_ready ? slow_addr : '0;
    wd         = fast_win ? fast_data : slow_ready ? slow_data : '0;
  end

  // hazard against registered pending only; bit 0 is never set so x0 never hazards
  always_comb begin
    hazard    = (pending_q[rs1] && ru.uses_rs1) || (pending_q[rs2] && ru.uses_rs2) ||
                (pending_q[rd] && ru.writes_rd);
    dec_stall = dec_valid && (hazard || starve_q);
    issue     = dec_valid && !dec_stall;
  end

  // scoreboard and starvation next-state; starve tracks the counter reaching the limit this edge
  always_comb begin
    pending_d = pending_q;
    if (slow_ready) pending_d[slow_addr] = 1'b0;
    if (issue && dec_long && ru.writes_rd && rd != '0) pending_d[rd] = 1'b1;
    pending_d[0] = 1'b0;
    cnt_d    = (slow_valid && !slow_ready) ? ((cnt_q == LIM) ? cnt_q : cnt_q + 1'b1) : '0;
    starve_d = cnt_d == LIM;
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
      starve_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
    end

endmodule

// File: tb/tb_regfile_scheduler.sv
// tb_regfile_scheduler: directed checks plus a write-port scoreboard for regfile_scheduler
module tb_regfile_scheduler;
  import defines::*;

  logic   clk = 1'b0;
  logic   rst_n;
  instr_t instr;
  logic   dec_valid, dec_long, dec_stall;
  logic   fast_valid, slow_valid, slow_ready, wren;
  r_t     fast_addr, slow_addr, waddr;
  data_t  fast_data, slow_data, wd;

  typedef struct {
    r_t    a;
    data_t d;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  regfile_scheduler dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .dec_valid(dec_valid), .dec_long(dec_long),
    .dec_stall(dec_stall), .fast_valid(fast_valid), .fast_addr(fast_addr),
    .fast_data(fast_data), .slow_valid(slow_valid), .slow_addr(slow_addr),
    .slow_data(slow_data), .slow_ready(slow_ready), .wren(wren), .waddr(waddr), .wd(wd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic instr_t i_lw(input r_t rd, input r_t rs1);
    return {12'd0, rs1, 3'b010, rd, OPC_LOAD};
  endfunction
  function automatic instr_t i_add(input r_t rd, input r_t rs1, input r_t rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, OPC_OP};
  endfunction
  function automatic instr_t i_sw(input r_t rs2, input r_t rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, OPC_STORE};
  endfunction
  function automatic instr_t i_lui(input r_t rd);
    return {20'h12345, rd, OPC_LUI};
  endfunction

  task automatic exp_wr(input r_t a, input data_t d);
    exp_q.push_back('{a, d});
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // every register-file write must match the oldest expected write
  always @(negedge clk)
    if (wren) begin
      if (exp_q.size() == 0) check("wr_unexpected", {27'd0, waddr}, 32'hffff_ffff);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {27'd0, waddr}, {27'd0, e.a});
        check("wr_data", wd, e.d);
      end
    end

  task automatic idle;
    dec_valid = 0; dec_long = 0; instr = '0;
    fast_valid = 0; fast_addr = '0; fast_data = '0;
    slow_valid = 0; slow_addr = '0; slow_data = '0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    smp();
    check("rst_stall", {31'd0, dec_stall}, 0);
    check("rst_ready", {31'd0, slow_ready}, 0);
    check("rst_wren", {31'd0, wren}, 0);
    nxt();
    rst_n = 1;
    nxt();

    // RAW: LW x5 long, ADD x6,x5,x1 stalls until x5 returns
    dec_valid = 1; dec_long = 1; instr = i_lw(5, 2);
    smp(); check("lw5_issue", {31'd0, dec_stall}, 0);
    nxt(); dec_long = 0; instr = i_add(6, 5, 1);
    smp(); check("raw_stall1", {31'd0, dec_stall}, 1);
    nxt();
    smp(); check("raw_stall2", {31'd0, dec_stall}, 1);
    nxt(); slow_valid = 1; slow_addr = 5; slow_data = 32'hA5A5_0005; exp_wr(5, 32'hA5A5_0005);
    smp(); check("raw_acc_ready", {31'd0, slow_ready}, 1);
    check("raw_no_bypass", {31'd0, dec_stall}, 1);
    nxt(); slow_valid = 0;
    smp(); check("raw_release", {31'd0, dec_stall}, 0);
    nxt(); idle();

    // fast beats slow, slow goes next cycle
    fast_valid = 1; fast_addr = 3; fast_data = 32'hF3; exp_wr(3, 32'hF3);
    slow_valid = 1; slow_addr = 7; slow_data = 32'h57;
    smp(); check("arb_wren", {31'd0, wren}, 1);
    check("arb_waddr", {27'd0, waddr}, 3);
    check("arb_refuse", {31'd0, slow_ready}, 0);
    nxt(); fast_valid = 0; exp_wr(7, 32'h57);
    smp(); check("arb_slow_ready", {31'd0, slow_ready}, 1);
    nxt(); idle();

    // fast to x0 is dropped; slow to x0 accepted without a write
    fast_valid = 1; fast_addr = 0; fast_data = 32'hDEAD;
    slow_valid = 1; slow_addr = 9; slow_data = 32'h99; exp_wr(9, 32'h99);
    smp(); check("x0fast_ready", {31'd0, slow_ready}, 1);
    check("x0fast_waddr", {27'd0, waddr}, 9);
    nxt(); fast_valid = 0; slow_addr = 0; slow_data = 32'h1234;
    smp(); check("x0slow_ready", {31'd0, slow_ready}, 1);
    check("x0slow_wren", {31'd0, wren}, 0);
    nxt(); idle();

    // starvation: slow x4 refused 3 cycles, decode throttled from cycle 4
    dec_valid = 1; instr = i_add(1, 2, 3);
    slow_valid = 1; slow_addr = 4; slow_data = 32'h44;
    fast_valid = 1;
    for (int c = 1; c <= 3; c++) begin
      fast_addr = 10; fast_data = 32'h100 + c; exp_wr(10, 32'h100 + c);
      smp();
      check("starve_refuse", {31'd0, slow_ready}, 0);
      check("starve_pre", {31'd0, dec_stall}, 0);
      nxt();
    end
    fast_data = 32'h104; exp_wr(10, 32'h104);
    smp(); check("starve_stall", {31'd0, dec_stall}, 1);
    nxt(); fast_valid = 0; exp_wr(4, 32'h44);
    smp(); check("starve_acc", {31'd0, slow_ready}, 1);
    check("starve_hold", {31'd0, dec_stall}, 1);
    nxt(); slow_valid = 0;
    smp(); check("starve_drop", {31'd0, dec_stall}, 0);
    nxt(); idle();

    // WAW: LW x8 pending, SW independent issues, LUI x8 stalls
    dec_valid = 1; dec_long = 1; instr = i_lw(8, 1);
    smp(); check("lw8_issue", {31'd0, dec_stall}, 0);
    nxt(); dec_long = 0; instr = i_sw(1, 2);
    smp(); check("sw_indep", {31'd0, dec_stall}, 0);
    nxt(); instr = i_lui(8);
    smp(); check("waw_stall", {31'd0, dec_stall}, 1);
    nxt(); slow_valid = 1; slow_addr = 8; slow_data = 32'h88; exp_wr(8, 32'h88);
    smp(); check("waw_hold", {31'd0, dec_stall}, 1);
    nxt(); slow_valid = 0;
    smp(); check("waw_release", {31'd0, dec_stall}, 0);
    nxt(); idle();

    // long op to x0 never creates a hazard
    dec_valid = 1; dec_long = 1; instr = i_lw(0, 1);
    nxt(); dec_long = 0; instr = i_add(6, 0, 0);
    smp(); check("x0_no_hazard", {31'd0, dec_stall}, 0);
    nxt(); idle();

    // reset with x5, x8 pending clears the scoreboard
    dec_valid = 1; dec_long = 1; instr = i_lw(5, 1);
    nxt(); instr = i_lw(8, 1);
    nxt(); dec_long = 0; instr = i_add(6, 5, 8);
    smp(); check("pre_rst_stall", {31'd0, dec_stall}, 1);
    nxt(); dec_valid = 0; rst_n = 0;
    nxt(); rst_n = 1; dec_valid = 1;
    smp(); check("post_rst_raw", {31'd0, dec_stall}, 0);
    nxt(); instr = i_lui(8);
    smp(); check("post_rst_waw", {31'd0, dec_stall}, 0);
    nxt(); idle(); slow_valid = 1; slow_addr = 5; slow_data = 32'h55; exp_wr(5, 32'h55);
    smp(); check("late_return", {31'd0, slow_ready}, 1);
    nxt(); idle();
    smp();
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
